// File: rtl/fa_pkg.sv
// Elaboration-time helpers for the pipelined adder: carry-chain segment
// geometry and the legality test for WIDTH/STAGES combinations.
package fa_pkg;

    // Segment width: the carry chain is cut into STAGES pieces of ceil(width/stages) bits.
    function automatic int seg_width(input int width, input int stages);
        if (stages < 1) begin
            return width;
        end
        return (width + stages - 1) / stages;
    endfunction

    // Index of the most significant bit belonging to segment k.
    // The last segment takes whatever remains, so clamp to the top bit.
    function automatic int seg_hi(input int width, input int stages, input int k);
        int hi;
        hi = (k + 1) * seg_width(width, stages) - 1;
        if (hi > width - 1) begin
            hi = width - 1;
        end
        return hi;
    endfunction

    // A configuration is legal when every segment, including the last, owns at least one bit.
    function automatic bit params_legal(input int width, input int stages);
        if (width < 1 || stages < 1 || stages > width) begin
            return 1'b0;
        end
        return ((stages - 1) * seg_width(width, stages)) < width;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder; the leaf of every carry segment.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    // Sum is the three-way parity; carry propagates when a^b and generates when a&b.
    assign s  = a ^ b ^ c;
    assign co = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/fa.sv
// Registered, optionally pipelined adder: {Cout,S} = A + B + Cin.
// The carry chain is split LSB-first into STAGES segments. Segment k works in
// pipeline stage k, so its operand bits are delayed k cycles and its sum bits
// are delayed a further STAGES-k cycles (the last of which is the output
// register). Every bit therefore crosses exactly STAGES registers, and every
// result emerges STAGES cycles after its operands were presented.
module fa
    import fa_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int SEG = seg_width(WIDTH, STAGES);

    // Refuse configurations that would leave the last segment without bits.
    if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
        $error("fa: illegal WIDTH/STAGES combination (need WIDTH>=1, 1<=STAGES<=WIDTH, non-empty last segment)");
    end

    genvar gi;

    // Per-bit datapath: operand skew, full-adder cell, sum deskew.
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
        localparam int K  = gi / SEG;     // segment / pipeline stage owning this bit
        localparam int DS = STAGES - K;   // sum registers after the cell, incl. output reg

        logic          a_st;
        logic          b_st;
        logic          c_st;
        logic          s_w;
        logic          co_w;
        logic [DS-1:0] s_pipe;

        if (K == 0) begin : g_direct
            assign a_st = A[gi];
            assign b_st = B[gi];
        end else begin : g_skew
            logic [K-1:0] a_dly;
            logic [K-1:0] b_dly;

            // Delay operand bits by K cycles so they meet the carry from the previous segment.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_dly <= '0;
                    b_dly <= '0;
                end else begin
                    a_dly <= (a_dly << 1) | K'(A[gi]);
                    b_dly <= (b_dly << 1) | K'(B[gi]);
                end
            end

            assign a_st = a_dly[K-1];
            assign b_st = b_dly[K-1];
        end

        // Carry into this bit: ripple inside a segment, registered carry at a segment boundary.
        if (gi % SEG != 0) begin : g_ripple
            assign c_st = g_bit[gi-1].co_w;
        end else if (K == 0) begin : g_cin
            assign c_st = Cin;
        end else begin : g_seg_cin
            assign c_st = g_seg[K-1].carry_q;
        end

        fa_cell u_cell (
            .a  (a_st),
            .b  (b_st),
            .c  (c_st),
            .s  (s_w),
            .co (co_w)
        );

        // Hold the sum bit until the slowest segment catches up; the last stage is the output register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_pipe <= '0;
            end else begin
                s_pipe <= (s_pipe << 1) | DS'(s_w);
            end
        end

        assign S[gi] = s_pipe[DS-1];
    end

    // Per-segment carry registers; the last one doubles as the Cout output register.
    for (gi = 0; gi < STAGES; gi++) begin : g_seg
        localparam int HI = seg_hi(WIDTH, STAGES, gi);

        logic carry_q;

        // Capture the carry leaving the top bit of this segment for the next stage.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                carry_q <= 1'b0;
            end else begin
                carry_q <= g_bit[HI].co_w;
            end
        end
    end

    assign Cout = g_seg[STAGES-1].carry_q;

endmodule

// File: tb/tb_fa.sv
// Self-checking bench for fa: three instances (1/1, 8/4, 7/3) driven in
// lockstep. The reference is plain arithmetic A+B+Cin pushed into a queue
// whose initial depth equals the instance latency.
module tb_fa;

    logic       clk = 1'b0;
    logic       rst;

    logic       a1, b1, c1, s1, co1;
    logic [7:0] a8, b8, s8;
    logic       c8, co8;
    logic [6:0] a7, b7, s7;
    logic       c7, co7;

    int total = 0;
    int bad   = 0;

    logic [1:0] q1[$];
    logic [8:0] q8[$];
    logic [7:0] q7[$];

    always #5 clk = ~clk;

    fa #(.WIDTH(1), .STAGES(1)) u_w1 (
        .clk (clk), .rst (rst), .A (a1), .B (b1), .Cin (c1), .S (s1), .Cout (co1)
    );

    fa #(.WIDTH(8), .STAGES(4)) u_w8 (
        .clk (clk), .rst (rst), .A (a8), .B (b8), .Cin (c8), .S (s8), .Cout (co8)
    );

    fa #(.WIDTH(7), .STAGES(3)) u_w7 (
        .clk (clk), .rst (rst), .A (a7), .B (b7), .Cin (c7), .S (s7), .Cout (co7)
    );

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Refill the reference queues with one zero result per pipeline stage.
    task automatic flush();
        q1.delete();
        q8.delete();
        q7.delete();
        q1.push_back(2'd0);
        repeat (4) q8.push_back(9'd0);
        repeat (3) q7.push_back(8'd0);
    endtask

    // Called at a falling edge: check outputs, present new operands, wait one cycle.
    task automatic step(input string tag,
                        input logic [2:0] v1,
                        input logic [7:0] x8, input logic [7:0] y8, input logic z8,
                        input logic [6:0] x7, input logic [6:0] y7, input logic z7);
        logic [8:0] e1, e8, e7;
        e1 = {7'd0, q1.pop_front()};
        e8 = q8.pop_front();
        e7 = {1'b0, q7.pop_front()};
        check({tag, " w1s1"}, {7'd0, co1, s1}, e1);
        check({tag, " w8s4"}, {co8, s8}, e8);
        check({tag, " w7s3"}, {1'b0, co7, s7}, e7);
        $display("step %s: w1 %b%b+%b | w8 %h+%h+%b | w7 %h+%h+%b", tag,
                 v1[2], v1[1], v1[0], x8, y8, z8, x7, y7, z7);
        a1 = v1[2];
        b1 = v1[1];
        c1 = v1[0];
        a8 = x8;
        b8 = y8;
        c8 = z8;
        a7 = x7;
        b7 = y7;
        c7 = z7;
        q1.push_back(2'(int'(v1[2]) + int'(v1[1]) + int'(v1[0])));
        q8.push_back(9'(int'(x8) + int'(y8) + int'(z8)));
        q7.push_back(8'(int'(x7) + int'(y7) + int'(z7)));
        @(negedge clk);
    endtask

    task automatic rand_step(input string tag);
        step(tag, 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
             7'($urandom), 7'($urandom), 1'($urandom));
    endtask

    initial begin
        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        a8 = '0;   b8 = '0;   c8 = 1'b0;
        a7 = '0;   b7 = '0;   c7 = 1'b0;
        flush();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed corner cases, including full-ripple carries through every segment.
        step("dir0", 3'b111, 8'hFF, 8'h01, 1'b0, 7'h7F, 7'h7F, 1'b1);
        step("dir1", 3'b101, 8'h7F, 8'h80, 1'b1, 7'h00, 7'h00, 1'b0);
        step("dir2", 3'b010, 8'h00, 8'h00, 1'b0, 7'h01, 7'h7E, 1'b1);
        step("dir3", 3'b000, 8'hFF, 8'hFF, 1'b1, 7'h07, 7'h01, 1'b0);

        // Every 1-bit combination on consecutive cycles.
        for (int i = 0; i < 8; i++) begin
            step("exh", 3'(i), 8'($urandom), 8'($urandom), 1'($urandom),
                 7'($urandom), 7'($urandom), 1'($urandom));
        end

        // Back-to-back random operands.
        for (int i = 0; i < 1000; i++) begin
            rand_step("rand");
        end

        // Asynchronous reset between edges: outputs must clear without a clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_async w1s1", {7'd0, co1, s1}, 9'd0);
        check("rst_async w8s4", {co8, s8}, 9'd0);
        check("rst_async w7s3", {1'b0, co7, s7}, 9'd0);
        repeat (2) @(negedge clk);
        check("rst_hold w8s4", {co8, s8}, 9'd0);
        rst = 1'b0;
        flush();

        for (int i = 0; i < 20; i++) begin
            rand_step("post_rst");
        end

        // Drain the pipelines so the last operands are checked too.
        for (int i = 0; i < 4; i++) begin
            step("drain", 3'b000, 8'h00, 8'h00, 1'b0, 7'h00, 7'h00, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fa.md
# fa

Registered, optionally pipelined full adder: adds two WIDTH-bit operands plus a carry-in and delivers a WIDTH-bit sum and a carry-out. With defaults (WIDTH=1, STAGES=1) it is a single-bit full adder with registered outputs. It is the arithmetic leaf used by wider datapaths. Larger WIDTH/STAGES settings split the carry chain into pipeline segments for timing closure.

## Interface
- WIDTH, 1, operand/sum width in bits (≥1)
- STAGES, 1, pipeline depth = number of carry-chain segments (1 ≤ STAGES ≤ WIDTH)
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous and active-high; clears all state
- A  input  WIDTH  operand A, unsigned
- B  input  WIDTH  operand B, unsigned
- Cin  input  1  carry-in, weight 2^0
- S  output  WIDTH  sum, (A+B+Cin) mod 2^WIDTH
- Cout  output  1  carry-out, bit WIDTH of A+B+Cin

## Operation
- Function: {Cout,S} = A + B + Cin, computed at WIDTH+1 bits, unsigned; no overflow flag, no signed interpretation.
- Carry chain partitioned LSB-first into STAGES segments; segment width SEG = ceil(WIDTH/STAGES); final segment takes the remainder (may be narrower, never empty; STAGES values giving an empty segment are illegal and rejected at elaboration).
- Segment k (0..STAGES-1) evaluates in pipeline stage k using the carry registered at the end of stage k-1 (stage 0 uses Cin).
- Operand skew: bits of A/B for segment k pass through k delay registers before use.
- Result deskew: sum bits of segment k pass through STAGES-1-k delay registers so all S bits and Cout emerge in the same cycle.
- Every pipeline register updates every cycle; no enable, no stall, no valid qualifier. A new operand set is accepted every cycle.
- Each bit computed by fa_cell: s = a^b^c, co = (a&b)|(c&(a^b)).

## Timing
- Latency: inputs sampled at rising edge n appear on S/Cout after edge n+STAGES-1 registers plus output register, i.e. valid after edge n+STAGES (STAGES=1: one cycle).
- Throughput: one result per cycle; consecutive operands never interact.
- S and Cout are registered outputs; no combinational path from inputs to outputs.
- Reset: while rst=1, S=0, Cout=0, every skew/carry/deskew register 0, immediately (asynchronous). On release, outputs show results of operands sampled after release, prefixed by STAGES-1... zero results flushing out (all-zero, not X).
- Reset mid-operation: in-flight results discarded; no partial result emerges.
- Input changes between edges have no effect on outputs until the next sampling edge.

## Structure
- Sub-module fa_cell: 1-bit combinational full adder (a, b, c -> s, co); fa instantiates WIDTH of them in generate loops.
- No shared package needed; SEG and per-segment bounds are localparams inside fa. Elaboration check for WIDTH ≥ 1 and 1 ≤ STAGES ≤ WIDTH with non-empty last segment.

## Test plan
- WIDTH=1, STAGES=1: A=1,B=1,Cin=1 -> one cycle later S=1,Cout=1; then A=1,B=0,Cin=1 -> S=0,Cout=1; then A=0,B=1,Cin=0 -> S=1,Cout=0.
- WIDTH=1 exhaustive: all 8 {A,B,Cin} combinations on consecutive cycles -> each {Cout,S} equals A+B+Cin exactly one cycle after its input.
- WIDTH=8, STAGES=4: A=0xFF,B=0x01,Cin=0 -> S=0x00,Cout=1 after 4 cycles (full carry ripple across all segments); A=0x7F,B=0x80,Cin=1 -> S=0x00,Cout=1.
- WIDTH=8, STAGES=4 back-to-back random operands every cycle for 1000 cycles -> each output matches reference sum delayed exactly 4 cycles, no cross-contamination.
- Reset: assert rst asynchronously mid-stream (between edges) -> S=0,Cout=0 immediately; after release, first 3 outputs all-zero, then results of post-reset operands with 4-cycle latency.
- WIDTH=7, STAGES=3 (uneven segments 3/3/1): A=0x7F,B=0x7F,Cin=1 -> S=0x7F,Cout=1 after 3 cycles.
